// File: rtl/reg_readback.sv
// Debug readback engine: snapshots the register bank on start, then streams every word
// over valid/ready followed by an XOR checksum beat.
module reg_readback #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 8,
  localparam int unsigned IW = $clog2(NREGS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NREGS*WIDTH-1:0] snap_in,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       out_data,
  output logic [IW-1:0]          out_idx,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam logic [IW-1:0] LastIdx = IW'(NREGS);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] snap_q [NREGS];
  logic             load;
  logic             at_sum;
  logic [WIDTH-1:0] cur_word;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  // Snapshot contents are irrelevant after reset, so no reset on the buffer.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NREGS; i++) begin
        snap_q[i] <= snap_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    cur_word = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx_q == IW'(i)) cur_word = snap_q[i];
    end
    at_sum = (idx_q == LastIdx);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          idx_d   = '0;
          sum_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (out_ready) begin
          if (at_sum) begin
            state_d = StDone;
          end else begin
            sum_d = sum_q ^ cur_word;
            idx_d = idx_q + IW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // All outputs decode registered state only; payload is forced to zero outside SEND.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    out_valid = (state_q == StSend);
    out_last  = out_valid && at_sum;
    out_data  = out_valid ? (at_sum ? sum_q : cur_word) : '0;
    out_idx   = out_valid ? idx_q : '0;
  end

endmodule

// File: doc/reg_readback.md
# reg_readback

Debug readback engine for the register bank: the read-side counterpart of the per-register write path. On a start request it snapshots every register's current value in one cycle. It then streams the values out one word per beat over a valid/ready interface, followed by an XOR checksum word. It sits between the CPU register bank (flattened bus) and the debug/host link serializer.

## Interface
- WIDTH, 8, bits per register word
- NREGS, 8, number of registers read back (NREGS >= 2)
- IW, $clog2(NREGS+1), width of beat index (derived, not overridden)

- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-low (rst==0 at a posedge resets)
- start  in  1  readback request, sampled only in IDLE
- snap_in  in  NREGS*WIDTH  register bank contents; register i at snap_in[i*WIDTH +: WIDTH]
- busy  out  1  high while a readback is in progress (SEND or DONE)
- done  out  1  one-cycle pulse after the checksum beat is accepted
- out_data  out  WIDTH  current beat payload
- out_idx  out  IW  register index of current beat; NREGS on checksum beat
- out_last  out  1  high only on checksum beat
- out_valid  out  1  beat present
- out_ready  in  1  consumer accepts beat when out_valid && out_ready at posedge

## Operation
- States: IDLE, SEND, DONE.
- IDLE: busy=0, out_valid=0. start==1 at posedge -> copy all of snap_in into internal snapshot buffer, idx<=0, sum<=0, go SEND.
- SEND: out_valid=1, out_data=snapshot[idx] for idx<NREGS, else sum; out_last=(idx==NREGS).
- Handshake (valid&&ready) in SEND: if idx<NREGS then sum<=sum^snapshot[idx], idx<=idx+1; if idx==NREGS go DONE.
- DONE: busy=1, done=1, out_valid=0; unconditionally go IDLE next cycle.
- Checksum = XOR of all NREGS snapshot words, exactly as sent.
- start in SEND or DONE is ignored (no restart, no re-snapshot).
- snap_in changes after the snapshot cycle have no effect on the stream.
- While out_valid && !out_ready: out_data, out_idx and out_last held stable; no beat skipped or repeated.
- Reset (rst==0 at any posedge, in any state): state<=IDLE; busy, done, out_valid, out_last, out_data, out_idx, idx and sum all <=0. Snapshot buffer contents don't matter. Reset dominates start.
- Outputs are registered or decoded from registered state only; no combinational path from out_ready or start to any output.

## Timing
- Start accepted at edge E0 -> busy=1 and out_valid=1 with register 0 from cycle after E0.
- With out_ready held 1: one beat per cycle, NREGS+1 beats in cycles 1..NREGS+1 after E0. Done pulse is in cycle NREGS+2. busy=0 and a new start is accepted from cycle NREGS+3.
- Each cycle with out_ready=0 during SEND adds exactly one cycle of latency.
- Minimum spacing between start acceptances: NREGS+3 cycles.

## Test plan
- Reset: drive rst=0 for 2 cycles with start=1 -> busy, done, out_valid, out_last, out_data, out_idx all 0; no readback begins.
- Streaming (NREGS=4, WIDTH=8, snap_in=32'h44332211, out_ready=1, start pulsed at E0) -> beats 0x11/0, 0x22/1, 0x33/2, 0x44/3. Then checksum beat 0x44/idx 4/out_last=1. done pulses in cycle 6; busy low in cycle 7.
- Backpressure: same setup, out_ready=0 for 3 cycles while beat 0x22 is presented -> 0x22/idx 1 held stable all 3 cycles. Full sequence and checksum unchanged; done delayed by 3 cycles.
- Snapshot isolation: change snap_in to 32'hFFFFFFFF one cycle after start -> stream still 0x11, 0x22, 0x33, 0x44, checksum 0x44.
- Start while busy: pulse start during SEND and again during the DONE cycle -> exactly one readback, single done pulse, busy low afterwards.
- Reset mid-operation: assert rst=0 after beat 0x22 is accepted -> out_valid=0, busy=0 the next cycle. Later start -> stream restarts at idx 0 with a fresh snapshot and correct checksum.
